fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register (pipe1) of the 16-bit pipelined core. Sits directly upstream of `decode` and produces its `fromPipe1PC`/`fromPipe1IR` inputs. Owns the word-addressed PC and runs a req/valid handshake to instruction memory. Honours stall from the hazard logic and redirects from branch/jump resolution, and holds at most one instruction in a skid register.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `imemReq` out 1: fetch request; `imemAddr` must stay stable while high until `imemValid`.
- `imemAddr` out 16: word address (current PC).
- `imemData` in 16: instruction word; sampled only when `imemValid` is high.
- `imemValid` in 1: one-cycle response pulse. May be high in the same cycle as `imemReq` (zero-wait memory).
- `stall` in 1: hold pipe1 contents (decode cannot accept).
- `redirect` in 1: one-cycle pulse; flush and restart at `redirectPC`.
- `redirectPC` in 16: branch/jump target.
- `pipe1PC` out 16: PC of the instruction in pipe1, to decode.
- `pipe1IR` out 16: instruction in pipe1, to decode.
- `pipe1PCInc` out 16: `pipe1PC+1`, the link value for JAL/JLR.
- `pipe1Valid` out 1: pipe1 holds a real instruction; 0 means bubble.

## Operation
- **Reset values**: state RESET; `pc`=RESET_PC; `pipe1PC`, `pipe1IR`, `pipe1PCInc`=0; `pipe1Valid`=0; skid empty.
- **imemReq**: high only in FETCH and DRAIN; low in RESET and HOLD. `imemAddr`=`pc` in every state.
- **RESET**: go to FETCH unconditionally on the next edge.
- **FETCH**
  - Response present (`imemValid`) and no `redirect`:
    - If `!stall`: pipe1 <= {`pc`, `imemData`, `pc+1`}, `pipe1Valid`<=1, `pc`<=`pc+1`, stay in FETCH.
    - If `stall`: skid <= {`pc`, `imemData`}, go to HOLD; pipe1 unchanged.
  - No response: if `!stall`, `pipe1Valid`<=0 (bubble); if `stall`, pipe1 holds.
- **HOLD**: no request issued.
  - When `!stall`: pipe1 <= skid, `pipe1Valid`<=1, `pc`<=`pc+1`, go to FETCH.
- **DRAIN**: the address of an abandoned request is kept on `imemAddr`.
  - On `imemValid`: discard data, go to FETCH with `pc` already equal to the redirect target.
  - `pipe1Valid` stays 0.
- **Redirect** (any state except RESET; takes priority over `stall` and any response):
  - `pipe1Valid`<=0 and skid cleared.
  - `pc`<=`redirectPC`, held in a target register until the drain completes.
  - In FETCH with `imemValid` in the same cycle: the response is discarded and the state stays FETCH.
  - In FETCH without a response: go to DRAIN.
  - In HOLD: go to FETCH.
  - In DRAIN: the target is replaced and the state stays DRAIN.
- **Arithmetic**: `pc+1` is modulo 2^16; 16'hFFFF wraps to 16'h0000, and `pipe1PCInc` wraps the same way.
- **Reset mid-operation**: asserting `resetn` low forces the reset values immediately, independent of the clock. Any in-flight response is ignored, because the state is RESET and `imemReq` is 0.

## Timing
- First instruction (zero-wait memory): `pipe1Valid`=1 after the 2nd rising edge following `resetn` release (edge 1 RESET→FETCH, edge 2 capture).
- Throughput: one instruction per cycle with zero-wait memory and no stall.
- Fetch-to-pipe1 latency: the edge on which `imemValid` is sampled high.
- Redirect penalty:
  - Response in the same cycle as the redirect: 1 bubble, then target fetch.
  - Request outstanding: bubbles until the drain response arrives, plus 1 cycle.
- `stall` is sampled every edge. A response arriving while stalled is never lost; it is held in the skid register.
- Outputs are registered, with no combinational path to pipe1 outputs. `imemReq` is decoded from state only.

## Configuration
- **`FETCH_PERF_EN` defined**: adds output ports `fetchCount` (16) and `stallCount` (16), both reset to 0 and wrapping modulo 2^16.
  - `fetchCount` increments on each pipe1 load with `pipe1Valid`<=1.
  - `stallCount` increments on each edge where `stall` is high and `pipe1Valid` is 1.
- **`FETCH_PERF_EN` undefined**: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - State encoding: RESET, FETCH, HOLD, DRAIN.
  - Default `RESET_PC`.
  - Instruction width 16 and the word/PC width.
  - Opcode constants shared with `decode`: JAL 4'b1000, JLR 4'b1001, BEQ 4'b1100.
- PC increment reuses the existing `add` module.
- One natural sub-module: `pipe1_reg`, the IF/ID register with load, hold, flush and async reset.

## Test plan
- **Reset, zero-wait memory**: with mem[0]=16'h1234 and mem[1]=16'h5678 → `pipe1IR`=16'h1234, `pipe1PC`=0, `pipe1PCInc`=1 after edge 2; `pipe1IR`=16'h5678 after edge 3.
- **Stall into skid**: `stall` high for 3 cycles while the response to address 5 arrives → pipe1 holds instruction 4 and `imemReq` is low. After release, `pipe1PC`=5 on the next edge, then 6; none dropped or duplicated.
- **Redirect with outstanding request**: memory latency 3, redirect to 16'h0040 one cycle after the request to 16'h0010 → `imemAddr` stays 16'h0010 until `imemValid`. That data is discarded; `pipe1Valid`=0 throughout; the next request is 16'h0040.
- **Redirect plus stall in HOLD**: both high in the same cycle → `pipe1Valid`=0, skid discarded, and the next `imemAddr` is `redirectPC`.
- **Wrap-around**: `RESET_PC`=16'hFFFF → `pipe1PC`=16'hFFFF with `pipe1PCInc`=16'h0000, and the next fetch address is 16'h0000.
- **Async reset mid-fetch**: `resetn` low between edges with `imemValid` high → outputs take reset values immediately and the response is not captured.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: state encoding, widths, reset PC
// and the opcode constants also used by decode.
package fetch_stage_pkg;

  localparam int unsigned INSN_W = 16;
  localparam int unsigned PC_W   = 16;

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [INSN_W-1:0] insn_t;

  localparam pc_t DEFAULT_RESET_PC = 16'h0000;

  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_FETCH,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_e;

  function automatic logic is_ctrl_op(input insn_t insn);
    return (insn[15:12] == OP_JAL) || (insn[15:12] == OP_JLR) ||
           (insn[15:12] == OP_BEQ);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/valid bus between the fetch stage (master) and memory.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  imemReq;
  pc_t   imemAddr;
  insn_t imemData;
  logic  imemValid;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemData,
    input  imemValid
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemData,
    output imemValid
  );
endinterface

// File: rtl/add.sv
// Generic modulo-2^WIDTH adder shared across the core's datapath.
module add #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/fetch_stage_pipe1_reg.sv
// IF/ID pipeline register: load, hold, flush (bubble) and async active-low reset.
module pipe1_reg
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  load,
  input  logic  flush,
  input  pc_t   ld_pc,
  input  insn_t ld_ir,
  input  pc_t   ld_inc,
  output pc_t   pc_q,
  output insn_t ir_q,
  output pc_t   inc_q,
  output logic  valid_q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q    <= '0;
      ir_q    <= '0;
      inc_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      pc_q    <= ld_pc;
      ir_q    <= ld_ir;
      inc_q   <= ld_inc;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC, imem req/valid handshake, one-entry skid and
// IF/ID register. Optional perf counters when FETCH_PERF_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter pc_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic  clk,
  input  logic  resetn,
  fetch_stage_if.master imem,
  input  logic  stall,
  input  logic  redirect,
  input  pc_t   redirectPC,
  output pc_t   pipe1PC,
  output insn_t pipe1IR,
  output pc_t   pipe1PCInc,
  output logic  pipe1Valid
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetchCount,
  output logic [15:0] stallCount
`endif
);

  localparam pc_t PC_ONE = 16'd1;

  fetch_state_e state, state_nxt;
  pc_t   pc, pc_nxt;
  pc_t   target, target_nxt;
  pc_t   skid_pc, skid_pc_nxt;
  insn_t skid_ir, skid_ir_nxt;
  pc_t   pc_inc;

  logic  p1_load, p1_flush;
  pc_t   p1_ld_pc;
  insn_t p1_ld_ir;

  add #(.WIDTH(PC_W)) u_pc_add (
    .a   (pc),
    .b   (PC_ONE),
    .sum (pc_inc)
  );

  assign imem.imemReq  = (state == ST_FETCH) || (state == ST_DRAIN);
  assign imem.imemAddr = pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_RESET;
      pc      <= RESET_PC;
      target  <= RESET_PC;
      skid_pc <= '0;
      skid_ir <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      target  <= target_nxt;
      skid_pc <= skid_pc_nxt;
      skid_ir <= skid_ir_nxt;
    end
  end

  // In DRAIN, pc keeps the abandoned address on imemAddr; the redirect target
  // waits in 'target' and is moved into pc once the stale response is consumed.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    target_nxt  = target;
    skid_pc_nxt = skid_pc;
    skid_ir_nxt = skid_ir;
    p1_load     = 1'b0;
    p1_flush    = 1'b0;
    p1_ld_pc    = pc;
    p1_ld_ir    = imem.imemData;

    unique case (state)
      ST_RESET: begin
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        if (redirect) begin
          p1_flush    = 1'b1;
          skid_pc_nxt = '0;
          skid_ir_nxt = '0;
          target_nxt  = redirectPC;
          if (imem.imemValid) begin
            pc_nxt = redirectPC;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end else if (imem.imemValid) begin
          if (!stall) begin
            p1_load = 1'b1;
            pc_nxt  = pc_inc;
          end else begin
            skid_pc_nxt = pc;
            skid_ir_nxt = imem.imemData;
            state_nxt   = ST_HOLD;
          end
        end else if (!stall) begin
          p1_flush = 1'b1;
        end
      end

      // pc still equals skid_pc here, so pc_inc is also the skid entry's link value.
      ST_HOLD: begin
        if (redirect) begin
          p1_flush    = 1'b1;
          skid_pc_nxt = '0;
          skid_ir_nxt = '0;
          target_nxt  = redirectPC;
          pc_nxt      = redirectPC;
          state_nxt   = ST_FETCH;
        end else if (!stall) begin
          p1_load   = 1'b1;
          p1_ld_pc  = skid_pc;
          p1_ld_ir  = skid_ir;
          pc_nxt    = pc_inc;
          state_nxt = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (redirect) begin
          p1_flush    = 1'b1;
          skid_pc_nxt = '0;
          skid_ir_nxt = '0;
          target_nxt  = redirectPC;
        end else if (imem.imemValid) begin
          pc_nxt    = target;
          state_nxt = ST_FETCH;
        end
      end

      default: begin
        state_nxt = ST_RESET;
      end
    endcase
  end

  pipe1_reg u_pipe1 (
    .clk     (clk),
    .resetn  (resetn),
    .load    (p1_load),
    .flush   (p1_flush),
    .ld_pc   (p1_ld_pc),
    .ld_ir   (p1_ld_ir),
    .ld_inc  (pc_inc),
    .pc_q    (pipe1PC),
    .ir_q    (pipe1IR),
    .inc_q   (pipe1PCInc),
    .valid_q (pipe1Valid)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetchCount <= '0;
      stallCount <= '0;
    end else begin
      if (p1_load && !p1_flush) fetchCount <= fetchCount + 16'd1;
      if (stall && pipe1Valid)  stallCount <= stallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk;
  logic resetn, resetn2;
  logic stall, redirect;
  pc_t  redirectPC;
  logic stall2, redirect2;
  pc_t  redirectPC2;

  pc_t   p1_pc, p1_inc, p2_pc, p2_inc;
  insn_t p1_ir, p2_ir;
  logic  p1_valid, p2_valid;

  logic  auto_mem, man_valid;
  insn_t man_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

`ifdef FETCH_PERF_EN
  logic [15:0] fc0, sc0, fc1, sc1;
`endif

  fetch_stage_if bus0 ();
  fetch_stage_if bus1 ();

  function automatic insn_t mem_word(input pc_t a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0001: return 16'h5678;
      default:  return a ^ 16'hBEEF;
    endcase
  endfunction

  assign bus0.imemValid = auto_mem ? bus0.imemReq : man_valid;
  assign bus0.imemData  = auto_mem ? mem_word(bus0.imemAddr) : man_data;
  assign bus1.imemValid = bus1.imemReq;
  assign bus1.imemData  = mem_word(bus1.imemAddr);

  fetch_stage dut (
    .clk        (clk),
    .resetn     (resetn),
    .imem       (bus0),
    .stall      (stall),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .pipe1PC    (p1_pc),
    .pipe1IR    (p1_ir),
    .pipe1PCInc (p1_inc),
    .pipe1Valid (p1_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetchCount (fc0),
    .stallCount (sc0)
`endif
  );

  fetch_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk        (clk),
    .resetn     (resetn2),
    .imem       (bus1),
    .stall      (stall2),
    .redirect   (redirect2),
    .redirectPC (redirectPC2),
    .pipe1PC    (p2_pc),
    .pipe1IR    (p2_ir),
    .pipe1PCInc (p2_inc),
    .pipe1Valid (p2_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetchCount (fc1),
    .stallCount (sc1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (p1_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", p1_valid); end
    total++; if (p1_pc !== 16'h0000) begin bad++; $display("FAIL rst_pc got=%h exp=0000", p1_pc); end
    total++; if (p1_ir !== 16'h0000) begin bad++; $display("FAIL rst_ir got=%h exp=0000", p1_ir); end
    total++; if (p1_inc !== 16'h0000) begin bad++; $display("FAIL rst_inc got=%h exp=0000", p1_inc); end
    total++; if (bus0.imemReq !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus0.imemReq); end
    total++; if (bus0.imemAddr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h exp=0000", bus0.imemAddr); end
    tick();
    total++; if (bus0.imemReq !== 1'b0) begin bad++; $display("FAIL rst_req_held got=%b exp=0", bus0.imemReq); end
    resetn = 1'b1;
  endtask

  task automatic test_zero_wait();
    tick();
    total++; if (bus0.imemReq !== 1'b1) begin bad++; $display("FAIL zw_req_e1 got=%b exp=1", bus0.imemReq); end
    total++; if (p1_valid !== 1'b0) begin bad++; $display("FAIL zw_valid_e1 got=%b exp=0", p1_valid); end
    tick();
    total++; if (p1_valid !== 1'b1) begin bad++; $display("FAIL zw_valid_e2 got=%b exp=1", p1_valid); end
    total++; if (p1_ir !== 16'h1234) begin bad++; $display("FAIL zw_ir_e2 got=%h exp=1234", p1_ir); end
    total++; if (p1_pc !== 16'h0000) begin bad++; $display("FAIL zw_pc_e2 got=%h exp=0000", p1_pc); end
    total++; if (p1_inc !== 16'h0001) begin bad++; $display("FAIL zw_inc_e2 got=%h exp=0001", p1_inc); end
    tick();
    total++; if (p1_ir !== 16'h5678) begin bad++; $display("FAIL zw_ir_e3 got=%h exp=5678", p1_ir); end
    total++; if (p1_pc !== 16'h0001) begin bad++; $display("FAIL zw_pc_e3 got=%h exp=0001", p1_pc); end
    for (int i = 2; i <= 4; i++) begin
      tick();
      total++; if (p1_pc !== 16'(i) || p1_valid !== 1'b1) begin
        bad++; $display("FAIL zw_stream got=%h/%b exp=%h/1", p1_pc, p1_valid, 16'(i));
      end
    end
  endtask

  task automatic test_stall_skid();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (p1_pc !== 16'h0004 || p1_ir !== mem_word(16'h0004) || p1_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold got=%h/%h/%b exp=0004/%h/1", p1_pc, p1_ir, p1_valid, mem_word(16'h0004));
      end
      total++; if (bus0.imemReq !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", bus0.imemReq); end
    end
    stall = 1'b0;
    tick();
    total++; if (p1_pc !== 16'h0005 || p1_ir !== mem_word(16'h0005)) begin
      bad++; $display("FAIL skid_release got=%h/%h exp=0005/%h", p1_pc, p1_ir, mem_word(16'h0005));
    end
    total++; if (bus0.imemAddr !== 16'h0006) begin bad++; $display("FAIL skid_next_addr got=%h exp=0006", bus0.imemAddr); end
    tick();
    total++; if (p1_pc !== 16'h0006 || p1_ir !== mem_word(16'h0006)) begin
      bad++; $display("FAIL skid_follow got=%h/%h exp=0006/%h", p1_pc, p1_ir, mem_word(16'h0006));
    end
  endtask

  task automatic test_redirect_outstanding();
    redirect = 1'b1; redirectPC = 16'h0010;
    tick();
    total++; if (p1_valid !== 1'b0) begin bad++; $display("FAIL redir_same_valid got=%b exp=0", p1_valid); end
    total++; if (bus0.imemAddr !== 16'h0010) begin bad++; $display("FAIL redir_same_addr got=%h exp=0010", bus0.imemAddr); end
    redirect = 1'b0; auto_mem = 1'b0; man_valid = 1'b0;
    tick();
    total++; if (bus0.imemAddr !== 16'h0010 || p1_valid !== 1'b0) begin
      bad++; $display("FAIL drain_wait0 got=%h/%b exp=0010/0", bus0.imemAddr, p1_valid);
    end
    redirect = 1'b1; redirectPC = 16'h0040;
    tick();
    redirect = 1'b0;
    total++; if (bus0.imemAddr !== 16'h0010 || bus0.imemReq !== 1'b1 || p1_valid !== 1'b0) begin
      bad++; $display("FAIL drain_enter got=%h/%b/%b exp=0010/1/0", bus0.imemAddr, bus0.imemReq, p1_valid);
    end
    tick();
    total++; if (bus0.imemAddr !== 16'h0010 || p1_valid !== 1'b0) begin
      bad++; $display("FAIL drain_hold got=%h/%b exp=0010/0", bus0.imemAddr, p1_valid);
    end
    man_valid = 1'b1; man_data = 16'hDEAD;
    tick();
    man_valid = 1'b0;
    total++; if (bus0.imemAddr !== 16'h0040 || bus0.imemReq !== 1'b1 || p1_valid !== 1'b0) begin
      bad++; $display("FAIL drain_done got=%h/%b/%b exp=0040/1/0", bus0.imemAddr, bus0.imemReq, p1_valid);
    end
    auto_mem = 1'b1;
    tick();
    total++; if (p1_pc !== 16'h0040 || p1_ir !== mem_word(16'h0040) || p1_valid !== 1'b1) begin
      bad++; $display("FAIL drain_target got=%h/%h/%b exp=0040/%h/1", p1_pc, p1_ir, p1_valid, mem_word(16'h0040));
    end
  endtask

  task automatic test_redirect_hold();
    stall = 1'b1;
    tick();
    total++; if (bus0.imemReq !== 1'b0 || p1_pc !== 16'h0040) begin
      bad++; $display("FAIL hold_enter got=%b/%h exp=0/0040", bus0.imemReq, p1_pc);
    end
    redirect = 1'b1; redirectPC = 16'h0123;
    tick();
    total++; if (p1_valid !== 1'b0) begin bad++; $display("FAIL hold_redir_valid got=%b exp=0", p1_valid); end
    total++; if (bus0.imemAddr !== 16'h0123 || bus0.imemReq !== 1'b1) begin
      bad++; $display("FAIL hold_redir_addr got=%h/%b exp=0123/1", bus0.imemAddr, bus0.imemReq);
    end
    redirect = 1'b0; stall = 1'b0;
    tick();
    total++; if (p1_pc !== 16'h0123 || p1_ir !== mem_word(16'h0123) || p1_valid !== 1'b1) begin
      bad++; $display("FAIL hold_redir_fetch got=%h/%h/%b exp=0123/%h/1", p1_pc, p1_ir, p1_valid, mem_word(16'h0123));
    end
  endtask

  task automatic test_async_reset();
    #3;
    resetn = 1'b0;
    #1;
    total++; if (p1_valid !== 1'b0 || p1_pc !== 16'h0000 || p1_ir !== 16'h0000 || p1_inc !== 16'h0000) begin
      bad++; $display("FAIL async_rst_p1 got=%b/%h/%h/%h exp=0/0000/0000/0000", p1_valid, p1_pc, p1_ir, p1_inc);
    end
    total++; if (bus0.imemReq !== 1'b0 || bus0.imemAddr !== 16'h0000) begin
      bad++; $display("FAIL async_rst_bus got=%b/%h exp=0/0000", bus0.imemReq, bus0.imemAddr);
    end
    tick();
    total++; if (p1_valid !== 1'b0 || p1_ir !== 16'h0000) begin
      bad++; $display("FAIL async_rst_nocap got=%b/%h exp=0/0000", p1_valid, p1_ir);
    end
    resetn = 1'b1;
    tick();
    tick();
    total++; if (p1_pc !== 16'h0000 || p1_ir !== 16'h1234 || p1_valid !== 1'b1) begin
      bad++; $display("FAIL async_rst_restart got=%h/%h/%b exp=0000/1234/1", p1_pc, p1_ir, p1_valid);
    end
  endtask

  task automatic test_wrap();
    total++; if (bus1.imemAddr !== 16'hFFFF || bus1.imemReq !== 1'b0) begin
      bad++; $display("FAIL wrap_rst got=%h/%b exp=FFFF/0", bus1.imemAddr, bus1.imemReq);
    end
    resetn2 = 1'b1;
    tick();
    tick();
    total++; if (p2_pc !== 16'hFFFF || p2_inc !== 16'h0000 || p2_ir !== mem_word(16'hFFFF)) begin
      bad++; $display("FAIL wrap_p1 got=%h/%h/%h exp=FFFF/0000/%h", p2_pc, p2_inc, p2_ir, mem_word(16'hFFFF));
    end
    total++; if (bus1.imemAddr !== 16'h0000) begin bad++; $display("FAIL wrap_addr got=%h exp=0000", bus1.imemAddr); end
    tick();
    total++; if (p2_pc !== 16'h0000 || p2_ir !== 16'h1234 || p2_inc !== 16'h0001) begin
      bad++; $display("FAIL wrap_next got=%h/%h/%h exp=0000/1234/0001", p2_pc, p2_ir, p2_inc);
    end
  endtask

  initial begin
    resetn = 1'b0; resetn2 = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirectPC = '0;
    stall2 = 1'b0; redirect2 = 1'b0; redirectPC2 = '0;
    auto_mem = 1'b1; man_valid = 1'b0; man_data = '0;
    test_reset();
    test_zero_wait();
    test_stall_skid();
    test_redirect_outstanding();
    test_redirect_hold();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
